note_period_selector: RTL and testbench

- Parametrised successor to the 12-key half-period selector.
- Synchronises and debounces NUM_KEYS raw key inputs, picks one active note by a selectable priority mode, and applies an octave shift.
- Optionally glides (portamento) the output half-period toward the new target.
- Output feeds the square-wave generator; half-period is in 48 kHz sample ticks.

---
 rtl/note_period_selector.sv | 179 +++++++++++++++++
 tb/tb_note_period_selector.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/note_period_selector.sv
// note_period_selector
//   Debounces NUM_KEYS raw key levels, selects one active note (lowest-index
//   or last-pressed priority), applies an octave shift and optionally glides
//   the output half-period toward the new target. The half-period is counted
//   in 48 kHz sample ticks and feeds the square-wave generator.
//
// Ports
//   clk                  in   system clock (12.288 MHz)
//   rst                  in   synchronous reset, active-high
//   keys                 in   raw asynchronous key levels, bit 0 = C4
//   mode                 in   0 = lowest-index priority, 1 = last-pressed priority
//   octave               in   0=C3, 1=C4, 2=C5, 3=C6
//   glide_en             in   enable portamento
//   current_half_period  out  half-period in sample ticks; 0 = silence
//   note_valid           out  a debounced key is active
//   note_index           out  index of the active key
//   note_on              out  one-cycle pulse when the active index changes to a valid note
module note_period_selector #(
    parameter int unsigned NUM_KEYS        = 12,
    parameter int unsigned PERIOD_W        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4096,
    parameter int unsigned GLIDE_DIV       = 1024,
    localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                mode,
    input  logic [1:0]          octave,
    input  logic                glide_en,
    output logic [PERIOD_W-1:0] current_half_period,
    output logic                note_valid,
    output logic [IDX_W-1:0]    note_index,
    output logic                note_on
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PW = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;

    // Base half-periods for the first octave of keys; keys 12..23 reuse the
    // table one octave up (halved).
    function automatic logic [7:0] base_of(input int unsigned k);
        logic [7:0] b;
        case (k % 12)
            0:       b = 8'd92;
            1:       b = 8'd87;
            2:       b = 8'd82;
            3:       b = 8'd77;
            4:       b = 8'd73;
            5:       b = 8'd69;
            6:       b = 8'd65;
            7:       b = 8'd61;
            8:       b = 8'd58;
            9:       b = 8'd55;
            10:      b = 8'd51;
            11:      b = 8'd49;
            default: b = 8'd0;
        endcase
        if (k >= 12) begin
            b = b >> 1;
        end
        return b;
    endfunction

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [CW-1:0]       cnt_q [NUM_KEYS];
    logic [CW-1:0]       cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] rise;

    logic [IDX_W-1:0]    last_key_q, last_key_d;
    logic [IDX_W-1:0]    lowest_idx, rise_idx, sel_idx;
    logic                last_held, any_held;

    logic [PERIOD_W-1:0] base_ext, shifted, target;
    logic [PERIOD_W-1:0] cur_q, cur_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                valid_q, note_on_q, note_on_d;
    logic [IDX_W-1:0]    index_q;

    // Debounce: a key's stable bit flips only after the synced level has
    // differed from it on DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // last_key follows the stable bits as they rise, so mode 1 sees the new
    // key on the same edge that mode 0 would.
    assign rise = stable_d & ~stable_q;

    always_comb begin
        lowest_idx = '0;
        rise_idx   = '0;
        last_held  = 1'b0;
        for (int unsigned i = NUM_KEYS; i > 0; i--) begin
            if (stable_q[i-1]) lowest_idx = IDX_W'(i - 1);
            if (rise[i-1])     rise_idx   = IDX_W'(i - 1);
        end
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (stable_q[i] && (IDX_W'(i) == last_key_q)) last_held = 1'b1;
        end
    end

    assign any_held   = |stable_q;
    assign last_key_d = (|rise) ? rise_idx : last_key_q;
    assign sel_idx    = (mode && last_held) ? last_key_q : lowest_idx;

    always_comb begin
        base_ext = PERIOD_W'(base_of(32'(sel_idx)));
        shifted  = base_ext << 1;
        target   = any_held ? (shifted >> octave) : '0;
    end

    // Glide: note on/off (either end zero) or glide disabled loads directly;
    // otherwise step one tick toward target each time the prescaler expires.
    always_comb begin
        cur_d   = cur_q;
        presc_d = presc_q;
        if (!glide_en || (cur_q == '0) || (target == '0)) begin
            cur_d   = target;
            presc_d = '0;
        end else if (cur_q == target) begin
            presc_d = '0;
        end else if (presc_q == PW'(GLIDE_DIV - 1)) begin
            presc_d = '0;
            cur_d   = (cur_q > target) ? (cur_q - 1'b1) : (cur_q + 1'b1);
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    assign note_on_d = any_held && (!valid_q || (sel_idx != index_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
            last_key_q <= '0;
            presc_q    <= '0;
            cur_q      <= '0;
            valid_q    <= 1'b0;
            index_q    <= '0;
            note_on_q  <= 1'b0;
        end else begin
            sync1_q    <= keys;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            last_key_q <= last_key_d;
            presc_q    <= presc_d;
            cur_q      <= cur_d;
            valid_q    <= any_held;
            index_q    <= sel_idx;
            note_on_q  <= note_on_d;
        end
    end

    assign current_half_period = cur_q;
    assign note_valid          = valid_q;
    assign note_index          = index_q;
    assign note_on             = note_on_q;

endmodule

// File: tb/tb_note_period_selector.sv
// Directed bench for note_period_selector: 24 keys, 4-cycle debounce,
// 2-cycle glide step. Outputs are sampled 1 time unit after each rising edge.
module tb_note_period_selector;

    logic        clk;
    logic        rst;
    logic [23:0] keys;
    logic        mode;
    logic [1:0]  octave;
    logic        glide_en;
    logic [7:0]  period;
    logic        valid;
    logic [4:0]  idx;
    logic        non;

    int checks = 0;
    int errors = 0;

    note_period_selector #(
        .NUM_KEYS(24),
        .PERIOD_W(8),
        .DEBOUNCE_CYCLES(4),
        .GLIDE_DIV(2)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .keys                (keys),
        .mode                (mode),
        .octave              (octave),
        .glide_en            (glide_en),
        .current_half_period (period),
        .note_valid          (valid),
        .note_index          (idx),
        .note_on             (non)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [4:0] i, input logic [7:0] p);
        check({tag, ".valid"},  32'(valid),  32'(v));
        check({tag, ".index"},  32'(idx),    32'(i));
        check({tag, ".period"}, 32'(period), 32'(p));
    endtask

    initial begin
        rst = 1'b1; keys = '0; mode = 1'b0; octave = 2'd1; glide_en = 1'b0;
        tick(2);
        expect_out("reset", 1'b0, 5'd0, 8'd0);
        check("reset.note_on", 32'(non), 32'd0);
        rst = 1'b0;

        // Key 9: latency exactly 7 edges, one-cycle note_on.
        keys = 24'd1 << 9;
        tick(6);
        expect_out("k9.edge6", 1'b0, 5'd0, 8'd0);
        tick(1);
        expect_out("k9.edge7", 1'b1, 5'd9, 8'd55);
        check("k9.note_on", 32'(non), 32'd1);
        tick(1);
        check("k9.note_on_drop", 32'(non), 32'd0);
        keys = '0;
        tick(6);
        expect_out("k9off.edge6", 1'b1, 5'd9, 8'd55);
        tick(1);
        expect_out("k9off.edge7", 1'b0, 5'd0, 8'd0);
        check("k9off.note_on", 32'(non), 32'd0);

        // 3-cycle glitch is rejected; 4-cycle press is accepted.
        keys = 24'd1;
        tick(3);
        keys = '0;
        tick(10);
        expect_out("glitch3", 1'b0, 5'd0, 8'd0);
        keys = 24'd1;
        tick(4);
        keys = '0;
        tick(3);
        expect_out("press4", 1'b1, 5'd0, 8'd92);
        tick(4);
        expect_out("press4.release", 1'b0, 5'd0, 8'd0);

        // Priority modes.
        keys = (24'd1 << 4) | (24'd1 << 7);
        tick(7);
        expect_out("m0.k4k7", 1'b1, 5'd4, 8'd73);
        mode = 1'b1;
        tick(1);
        expect_out("m1.k4k7", 1'b1, 5'd4, 8'd73);
        keys = keys | (24'd1 << 2);
        tick(7);
        expect_out("m1.k2", 1'b1, 5'd2, 8'd82);
        keys = keys | (24'd1 << 11);
        tick(7);
        expect_out("m1.k11", 1'b1, 5'd11, 8'd49);
        mode = 1'b0;
        tick(1);
        expect_out("m0.switch", 1'b1, 5'd2, 8'd82);
        mode = 1'b1;
        tick(1);
        expect_out("m1.switch", 1'b1, 5'd11, 8'd49);
        keys = keys & ~(24'd1 << 11);
        tick(7);
        expect_out("m1.rel11", 1'b1, 5'd2, 8'd82);
        check("m1.rel11.note_on", 32'(non), 32'd1);
        keys = '0;
        mode = 1'b0;
        tick(7);
        expect_out("m.allrel", 1'b0, 5'd0, 8'd0);

        // Octave sweep on key 0, then upper-range key 21.
        keys = 24'd1;
        tick(7);
        expect_out("oct1", 1'b1, 5'd0, 8'd92);
        octave = 2'd0; tick(1);
        check("oct0", 32'(period), 32'd184);
        octave = 2'd2; tick(1);
        check("oct2", 32'(period), 32'd46);
        octave = 2'd3; tick(1);
        check("oct3", 32'(period), 32'd23);
        octave = 2'd1;
        keys = 24'd1 << 21;
        tick(7);
        expect_out("k21", 1'b1, 5'd21, 8'd27);
        keys = '0;
        tick(7);
        expect_out("k21.rel", 1'b0, 5'd0, 8'd0);

        // Glide 92 -> 55, one tick every 2 cycles, then immediate release.
        glide_en = 1'b1;
        keys = 24'd1;
        tick(7);
        expect_out("g.k0", 1'b1, 5'd0, 8'd92);
        keys = 24'd1 << 9;
        tick(7);
        expect_out("g.start", 1'b1, 5'd9, 8'd92);
        check("g.note_on", 32'(non), 32'd1);
        tick(1);
        check("g.e8", 32'(period), 32'd91);
        tick(1);
        check("g.e9", 32'(period), 32'd91);
        tick(1);
        check("g.e10", 32'(period), 32'd90);
        tick(69);
        check("g.e79", 32'(period), 32'd56);
        tick(1);
        check("g.e80", 32'(period), 32'd55);
        tick(10);
        check("g.hold", 32'(period), 32'd55);
        keys = '0;
        tick(6);
        check("g.rel.e6", 32'(period), 32'd55);
        tick(1);
        expect_out("g.rel.e7", 1'b0, 5'd0, 8'd0);

        // Reset mid-glide at 80; key re-debounces from zero with no glide.
        keys = 24'd1;
        tick(7);
        check("r.k0", 32'(period), 32'd92);
        keys = 24'd1 << 9;
        tick(7);
        tick(23);
        check("r.at80", 32'(period), 32'd80);
        rst = 1'b1;
        tick(1);
        expect_out("r.reset", 1'b0, 5'd0, 8'd0);
        check("r.reset.note_on", 32'(non), 32'd0);
        rst = 1'b0;
        tick(6);
        expect_out("r.e6", 1'b0, 5'd0, 8'd0);
        tick(1);
        expect_out("r.e7", 1'b1, 5'd9, 8'd55);
        check("r.note_on", 32'(non), 32'd1);
        tick(1);
        check("r.noglide", 32'(period), 32'd55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
